// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, ALU code and alu_op encodings for the LEGv8 ALU control path
package alu_pkg;

    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_EOR  = 11'h650;
    localparam logic [10:0] OP_LSL  = 11'h69B;
    localparam logic [10:0] OP_LSR  = 11'h69A;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_EOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_LSL  = 4'b1000;
    localparam logic [3:0] ALU_LSR  = 4'b1001;

    typedef enum logic [1:0] {
        ALU_OP_MEM   = 2'b00,
        ALU_OP_CBZ   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_UNDEF = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_rtype_decode.sv
// alu_rtype_decode: R-type opcode to ALU code; EOR/LSL/LSR recognised only with ALU_CTRL_SHIFT_EN
module alu_rtype_decode
    import alu_pkg::*;
(
    input  logic [10:0] opcode,
    output logic [3:0]  code,
    output logic        illegal
);

    // Exact opcode match; unknown or X/Z opcodes fall to AND and are flagged
    always_comb begin
        code    = ALU_AND;
        illegal = 1'b0;
        case (opcode)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_ORR:  code = ALU_ORR;
`ifdef ALU_CTRL_SHIFT_EN
            OP_EOR:  code = ALU_EOR;
            OP_LSL:  code = ALU_LSL;
            OP_LSR:  code = ALU_LSR;
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit: registered LEGv8 ALU control decoder; ALU_CTRL_SHIFT_EN adds EOR/LSL/LSR
module alu_control_unit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_l,
    input  logic        stall,
    input  logic [1:0]  alu_op,
    input  logic [10:0] opcode,
    output logic [3:0]  alu_control,
    output logic        illegal
);

    logic [3:0] r_code;
    logic       r_illegal;
    logic [3:0] next_code;
    logic       next_illegal;

    alu_rtype_decode u_rtype (
        .opcode  (opcode),
        .code    (r_code),
        .illegal (r_illegal)
    );

    // Select the operation class; undefined or X/Z alu_op falls to AND without a flag
    always_comb begin
        next_code    = ALU_AND;
        next_illegal = 1'b0;
        case (alu_op)
            ALU_OP_MEM:   next_code = ALU_ADD;
            ALU_OP_CBZ:   next_code = ALU_PASS;
            ALU_OP_RTYPE: begin
                next_code    = r_code;
                next_illegal = r_illegal;
            end
            default: ;
        endcase
    end

    // Output registers aligned to execute-stage operands; stall holds them
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            alu_control <= ALU_AND;
            illegal     <= 1'b0;
        end else if (!stall) begin
            alu_control <= next_code;
            illegal     <= next_illegal;
        end
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: randomized and directed checks of alu_control_unit against a table-driven model
module tb_alu_control_unit;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [10:0] opcode = 11'h000;
    logic [3:0]  alu_control;
    logic        illegal;

    int total = 0;
    int passed = 0;

`ifdef ALU_CTRL_SHIFT_EN
    localparam int RT_N = 7;
`else
    localparam int RT_N = 4;
`endif
    localparam logic [10:0] RT_OP   [7] = '{11'h458, 11'h658, 11'h450, 11'h550, 11'h650, 11'h69B, 11'h69A};
    localparam logic [3:0]  RT_CODE [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1000, 4'b1001};

    alu_control_unit dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .stall       (stall),
        .alu_op      (alu_op),
        .opcode      (opcode),
        .alu_control (alu_control),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Expected {code, illegal} from the instruction-class rules
    function automatic logic [4:0] model(input logic [1:0] op, input logic [10:0] oc);
        if (op == 2'd0) return {4'b0010, 1'b0};
        if (op == 2'd1) return {4'b0111, 1'b0};
        if (op == 2'd3) return {4'b0000, 1'b0};
        for (int i = 0; i < RT_N; i++)
            if (RT_OP[i] == oc) return {RT_CODE[i], 1'b0};
        return {4'b0000, 1'b1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst_l = 1'b0;
        alu_op = 2'b10;
        opcode = 11'h123;
        #2;
        got = {alu_control, illegal};
        total++;
        if (got !== 5'b00000) $display("FAIL reset_initial got=%b required=%b", got, 5'b00000);
        else passed++;
        step();
        got = {alu_control, illegal};
        total++;
        if (got !== 5'b00000) $display("FAIL reset_held got=%b required=%b", got, 5'b00000);
        else passed++;
        #3 rst_l = 1'b1;
        step();
        got = {alu_control, illegal};
        total++;
        if (got !== 5'b00001) $display("FAIL reset_release_illegal got=%b required=%b", got, 5'b00001);
        else passed++;
        opcode = 11'h658;
        #2 rst_l = 1'b0;
        #1;
        got = {alu_control, illegal};
        total++;
        if (got !== 5'b00000) $display("FAIL reset_async got=%b required=%b", got, 5'b00000);
        else passed++;
        step();
        got = {alu_control, illegal};
        total++;
        if (got !== 5'b00000) $display("FAIL reset_midrun_held got=%b required=%b", got, 5'b00000);
        else passed++;
        #3 rst_l = 1'b1;
        step();
        got = {alu_control, illegal};
        total++;
        if (got !== 5'b01100) $display("FAIL reset_release_sub got=%b required=%b", got, 5'b01100);
        else passed++;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [10:0] ocs [12] = '{11'h7C2, 11'h7C0, 11'h0A7, 11'h0A0, 11'h5A7, 11'h5A0, 11'h7FF,
                                  11'h458, 11'h658, 11'h450, 11'h550, 11'h123};
        logic [4:0]  exp [12] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110, 5'b01110, 5'b00000,
                                  5'b00100, 5'b01100, 5'b00000, 5'b00010, 5'b00001};
        logic [4:0]  got;
        for (int i = 0; i < 12; i++) begin
            alu_op = ops[i];
            opcode = ocs[i];
            step();
            got = {alu_control, illegal};
            total++;
            if (got !== exp[i])
                $display("FAIL directed[%0d] op=%b opcode=%h got=%b required=%b", i, ops[i], ocs[i], got, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_stall();
        logic [4:0] got;
        alu_op = 2'b00;
        opcode = 11'h7C2;
        step();
        stall = 1'b1;
        alu_op = 2'b10;
        opcode = 11'h658;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {alu_control, illegal};
            total++;
            if (got !== 5'b00100) $display("FAIL stall_hold[%0d] got=%b required=%b", i, got, 5'b00100);
            else passed++;
        end
        stall = 1'b0;
        step();
        got = {alu_control, illegal};
        total++;
        if (got !== 5'b01100) $display("FAIL stall_release got=%b required=%b", got, 5'b01100);
        else passed++;
        stall = 1'b1;
        rst_l = 1'b0;
        #1;
        got = {alu_control, illegal};
        total++;
        if (got !== 5'b00000) $display("FAIL stall_reset got=%b required=%b", got, 5'b00000);
        else passed++;
        #2 rst_l = 1'b1;
        stall = 1'b0;
    endtask

    task automatic test_config();
        logic [10:0] ocs [3] = '{11'h650, 11'h69B, 11'h69A};
`ifdef ALU_CTRL_SHIFT_EN
        logic [4:0]  exp [3] = '{5'b00110, 5'b10000, 5'b10010};
`else
        logic [4:0]  exp [3] = '{5'b00001, 5'b00001, 5'b00001};
`endif
        logic [4:0]  got;
        alu_op = 2'b10;
        for (int i = 0; i < 3; i++) begin
            opcode = ocs[i];
            step();
            got = {alu_control, illegal};
            total++;
            if (got !== exp[i]) $display("FAIL config opcode=%h got=%b required=%b", ocs[i], got, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [4:0]  held;
        logic [4:0]  got;
        held = {alu_control, illegal};
        for (int i = 0; i < 300; i++) begin
            alu_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       opcode = RT_OP[$urandom_range(0, 6)];
                1:       opcode = ($urandom_range(0, 1) == 0) ? 11'h7C2 : 11'h7C0;
                default: opcode = 11'($urandom);
            endcase
            stall = ($urandom_range(0, 4) == 0);
            #3;
            got = {alu_control, illegal};
            total++;
            if (got !== held) $display("FAIL random_between_edges[%0d] got=%b required=%b", i, got, held);
            else passed++;
            if (!stall) held = model(alu_op, opcode);
            step();
            got = {alu_control, illegal};
            total++;
            if (got !== held)
                $display("FAIL random[%0d] op=%b opcode=%h stall=%b got=%b required=%b", i, alu_op, opcode, stall, got, held);
            else passed++;
        end
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_config();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
